melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Upstream control stage for the square-wave tone generator.
- Steps through a fixed 8-entry song ROM, one entry at a time. Each entry is a pitch code and a duration in beats.
- Drives the generator's half-period value and a tone enable, and inserts a short silent articulation gap at the end of every note.
- Started and stopped by game logic; optional looping for background music.

Parameters:
BEAT_CYCLES, 12500000, clock cycles per beat (125 ms at 100 MHz); must be greater than GAP_CYCLES.
GAP_CYCLES, 1250000, silent cycles at the end of each entry; must be at least 1.
CNT_W, 32, width of the internal duration counter.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-low reset
start  input  1  level-sampled; begins the song from entry 0 when idle
stop  input  1  synchronous abort; has priority over start
loop_en  input  1  when 1, entry 7 wraps to entry 0 instead of finishing
half_period  output  32  generator half-period in clock cycles; 0 means silent
tone_on  output  1  generator enable
busy  output  1  high in FETCH, PLAY and GAP
note_index  output  3  index of the current ROM entry
song_done  output  1  one-cycle pulse when the song completes

Behaviour:
- Outputs: all outputs are registered.
- Reset: reset=0 immediately clears all outputs to 0 (no clock edge needed) and forces IDLE with index 0.
- Pitch table (half-period cycles): 0=rest/0, 1=C4/191113, 2=D4/170262, 3=E4/151685, 4=F4/143172, 5=G4/127551, 6=A4/113636, 7=B4/101238, 8=C5/95556. Codes 9-15 are treated as rest.
- Song ROM, as {code,beats} for index 0..7: {3,1} {3,1} {0,1} {3,1} {0,1} {1,1} {3,2} {5,4}.
- IDLE:
  - Outputs are 0.
  - start=1 and stop=0 at an edge -> FETCH, index=0.
- FETCH (1 cycle):
  - Latch code and beats for ROM[index].
  - Load the timer with beats*BEAT_CYCLES-GAP_CYCLES.
  - tone_on=0, half_period=0, busy=1.
- PLAY:
  - Outputs half_period=table[code] and tone_on=(table[code]!=0).
  - Timer decrements once per cycle. PLAY lasts exactly beats*BEAT_CYCLES-GAP_CYCLES cycles, then GAP with timer=GAP_CYCLES.
- GAP:
  - half_period=0, tone_on=0 for exactly GAP_CYCLES cycles.
  - On expiry with index<7: index+1, go to FETCH.
  - On expiry with index=7 and loop_en=1: index=0, go to FETCH; no song_done.
  - On expiry with index=7 and loop_en=0: go to DONE.
  - loop_en is sampled only at this expiry.
- DONE (1 cycle): song_done=1, busy=0, then IDLE.
- Entry length: each entry occupies exactly 1+beats*BEAT_CYCLES cycles.
- Full song (no loop): 8 + 12*BEAT_CYCLES cycles from FETCH of entry 0 to DONE.
- start while busy: ignored; no restart.
- start still high on return to IDLE: the song restarts (level-sampled).
- stop=1 in FETCH, PLAY or GAP: next cycle is IDLE, all outputs 0, index 0, no song_done.
- stop=1 in DONE: song_done still pulses.
- Simultaneous start and stop in IDLE: remain IDLE.
- Arithmetic: beats*BEAT_CYCLES is computed in CNT_W bits; the parameter set must not overflow it.

Optional Feature:
MELODY_TRANSPOSE_EN
- Defined: adds input port octave_up (1 bit), sampled in FETCH. When 1, half_period for that entry is table[code]>>1 (one octave up); rests are unaffected.
- Undefined: no octave_up port; half_period is always table[code].

Test Plan:
- Reset: reset=0 for 3 cycles mid-PLAY, with no clock edge required -> all outputs 0 immediately; after release, IDLE with note_index=0.
- Basic note timing (BEAT_CYCLES=10, GAP_CYCLES=2): start pulse -> busy=1 at the next edge; entry 0 gives 1 FETCH cycle, then 8 cycles of half_period=151685 with tone_on=1, then 2 silent cycles; entry 1 FETCH follows.
- Full song (same parameters, loop_en=0): 128 cycles from first FETCH to song_done; song_done high exactly 1 cycle; busy=0 afterwards; entry 7 plays half_period=127551 for 38 cycles; entries 2 and 4 keep tone_on=0 for 11 cycles each while busy=1.
- Looping: loop_en=1 -> after entry 7 GAP, note_index=0 and half_period=151685 again; song_done never asserts.
- Stop and ignored start: stop=1 during entry 7 PLAY -> next cycle tone_on=0, half_period=0, busy=0, note_index=0, no song_done. A start pulse during busy causes no restart (note_index continues unchanged).
- Transpose (MELODY_TRANSPOSE_EN defined, octave_up=1): entry 0 half_period=75842, entry 7 half_period=63775.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the game logic and melody_sequencer.
// The game logic side uses the master modport; the sequencer uses the slave modport.
interface melody_sequencer_if;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [31:0] half_period;
   logic        tone_on;
   logic        busy;
   logic [2:0]  note_index;
   logic        song_done;

   modport master (
      output start, stop, loop_en,
      input  half_period, tone_on, busy, note_index, song_done
   );

   modport slave (
      input  start, stop, loop_en,
      output half_period, tone_on, busy, note_index, song_done
   );
endinterface

// File: rtl/melody_sequencer.sv
// Steps an 8-entry song ROM and drives a square-wave generator's half-period and enable.
// Optional octave transpose input is enabled by defining MELODY_TRANSPOSE_EN.
module melody_sequencer #(
   parameter int unsigned BEAT_CYCLES = 12500000,
   parameter int unsigned GAP_CYCLES  = 1250000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic clk,
   input  logic reset,
`ifdef MELODY_TRANSPOSE_EN
   input  logic octave_up,
`endif
   melody_sequencer_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_t;

   state_t           r_state, w_nextState;
   logic [2:0]       r_index, w_nextIndex;
   logic [CNT_W-1:0] r_timer, w_nextTimer;
   logic [31:0]      r_halfPeriod, w_nextHalf;
   logic             r_toneOn, r_busy, r_songDone;
   logic             w_nextBusy, w_nextDone;
   logic [3:0]       w_romCode;
   logic [2:0]       w_romBeats;
   logic [31:0]      w_pitch, w_fetchHalf;
   logic [CNT_W-1:0] w_playLen;

   function automatic logic [31:0] pitchHalf(input logic [3:0] code);
      case (code)
         4'd1:    pitchHalf = 32'd191113;
         4'd2:    pitchHalf = 32'd170262;
         4'd3:    pitchHalf = 32'd151685;
         4'd4:    pitchHalf = 32'd143172;
         4'd5:    pitchHalf = 32'd127551;
         4'd6:    pitchHalf = 32'd113636;
         4'd7:    pitchHalf = 32'd101238;
         4'd8:    pitchHalf = 32'd95556;
         default: pitchHalf = 32'd0;
      endcase
   endfunction

   always_comb begin
      w_romCode  = 4'd0;
      w_romBeats = 3'd1;
      case (r_index)
         3'd0:    begin w_romCode = 4'd3; w_romBeats = 3'd1; end
         3'd1:    begin w_romCode = 4'd3; w_romBeats = 3'd1; end
         3'd2:    begin w_romCode = 4'd0; w_romBeats = 3'd1; end
         3'd3:    begin w_romCode = 4'd3; w_romBeats = 3'd1; end
         3'd4:    begin w_romCode = 4'd0; w_romBeats = 3'd1; end
         3'd5:    begin w_romCode = 4'd1; w_romBeats = 3'd1; end
         3'd6:    begin w_romCode = 4'd3; w_romBeats = 3'd2; end
         default: begin w_romCode = 4'd5; w_romBeats = 3'd4; end
      endcase
   end

   assign w_pitch   = pitchHalf(w_romCode);
   assign w_playLen = CNT_W'(w_romBeats) * CNT_W'(BEAT_CYCLES) - CNT_W'(GAP_CYCLES);

`ifdef MELODY_TRANSPOSE_EN
   assign w_fetchHalf = octave_up ? (w_pitch >> 1) : w_pitch;
`else
   assign w_fetchHalf = w_pitch;
`endif

   // Outputs are computed for the next state so the registered values line up with that state.
   always_comb begin
      w_nextState = r_state;
      w_nextIndex = r_index;
      w_nextTimer = r_timer;
      w_nextHalf  = r_halfPeriod;
      unique case (r_state)
         S_IDLE: begin
            w_nextHalf  = 32'd0;
            w_nextIndex = 3'd0;
            if (bus.start && !bus.stop) w_nextState = S_FETCH;
         end
         S_FETCH: begin
            w_nextState = S_PLAY;
            w_nextTimer = w_playLen;
            w_nextHalf  = w_fetchHalf;
         end
         S_PLAY: begin
            if (r_timer == CNT_W'(1)) begin
               w_nextState = S_GAP;
               w_nextTimer = CNT_W'(GAP_CYCLES);
               w_nextHalf  = 32'd0;
            end else begin
               w_nextTimer = r_timer - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (r_timer == CNT_W'(1)) begin
               if (r_index != 3'd7) begin
                  w_nextIndex = r_index + 3'd1;
                  w_nextState = S_FETCH;
               end else if (bus.loop_en) begin
                  w_nextIndex = 3'd0;
                  w_nextState = S_FETCH;
               end else begin
                  w_nextState = S_DONE;
               end
            end else begin
               w_nextTimer = r_timer - CNT_W'(1);
            end
         end
         S_DONE: begin
            w_nextState = S_IDLE;
            w_nextIndex = 3'd0;
            w_nextHalf  = 32'd0;
         end
         default: begin
            w_nextState = S_IDLE;
            w_nextIndex = 3'd0;
            w_nextHalf  = 32'd0;
         end
      endcase
      if (bus.stop && (r_state == S_FETCH || r_state == S_PLAY || r_state == S_GAP)) begin
         w_nextState = S_IDLE;
         w_nextIndex = 3'd0;
         w_nextTimer = '0;
         w_nextHalf  = 32'd0;
      end
      w_nextBusy = (w_nextState == S_FETCH) || (w_nextState == S_PLAY) || (w_nextState == S_GAP);
      w_nextDone = (w_nextState == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_index      <= 3'd0;
         r_timer      <= '0;
         r_halfPeriod <= 32'd0;
         r_toneOn     <= 1'b0;
         r_busy       <= 1'b0;
         r_songDone   <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_index      <= w_nextIndex;
         r_timer      <= w_nextTimer;
         r_halfPeriod <= w_nextHalf;
         r_toneOn     <= (w_nextHalf != 32'd0);
         r_busy       <= w_nextBusy;
         r_songDone   <= w_nextDone;
      end
   end

   assign bus.half_period = r_halfPeriod;
   assign bus.tone_on     = r_toneOn;
   assign bus.busy        = r_busy;
   assign bus.note_index  = r_index;
   assign bus.song_done   = r_songDone;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: stimulus pushes per-cycle expected outputs, a monitor pops and compares.
// Build with MELODY_TRANSPOSE_EN defined to exercise the octave_up path.
module tb_melody_sequencer;

   localparam int BEAT = 10;
   localparam int GAPC = 2;

   typedef struct packed {
      logic [31:0] half;
      logic        tone;
      logic        busy;
      logic [2:0]  idx;
      logic        done;
   } snap_t;

   logic clk;
   logic reset;
`ifdef MELODY_TRANSPOSE_EN
   logic octave_up;
`endif

   melody_sequencer_if bus ();

   melody_sequencer #(
      .BEAT_CYCLES (BEAT),
      .GAP_CYCLES  (GAPC),
      .CNT_W       (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef MELODY_TRANSPOSE_EN
      .octave_up (octave_up),
`endif
      .bus       (bus)
   );

   snap_t expQ[$];
   string tagQ[$];
   int    checkCount = 0;
   int    passCount  = 0;

   int          songBeats [8] = '{1, 1, 1, 1, 1, 1, 2, 4};
`ifdef MELODY_TRANSPOSE_EN
   logic [31:0] songHalf  [8] = '{32'd75842, 32'd75842, 32'd0, 32'd75842, 32'd0, 32'd95556, 32'd75842, 32'd63775};
`else
   logic [31:0] songHalf  [8] = '{32'd151685, 32'd151685, 32'd0, 32'd151685, 32'd0, 32'd191113, 32'd151685, 32'd127551};
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input snap_t e);
      checkCount++;
      if (bus.half_period === e.half && bus.tone_on === e.tone && bus.busy === e.busy &&
          bus.note_index === e.idx && bus.song_done === e.done) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got half=%0d tone=%0b busy=%0b idx=%0d done=%0b, expected half=%0d tone=%0b busy=%0b idx=%0d done=%0b",
                  tag, bus.half_period, bus.tone_on, bus.busy, bus.note_index, bus.song_done,
                  e.half, e.tone, e.busy, e.idx, e.done);
      end
   endtask

   task automatic pushSnap(input logic [31:0] h, input logic t, input logic b,
                           input logic [2:0] i, input logic d, input string tag);
      snap_t s;
      s.half = h; s.tone = t; s.busy = b; s.idx = i; s.done = d;
      expQ.push_back(s);
      tagQ.push_back(tag);
   endtask

   task automatic pushIdle(input int n, input string tag);
      for (int k = 0; k < n; k++) pushSnap(32'd0, 1'b0, 1'b0, 3'd0, 1'b0, tag);
   endtask

   task automatic pushEntry(input int e, input int playLimit);
      int playLen;
      playLen = songBeats[e] * BEAT - GAPC;
      pushSnap(32'd0, 1'b0, 1'b1, 3'(e), 1'b0, $sformatf("e%0d fetch", e));
      for (int c = 0; c < playLen && c < playLimit; c++)
         pushSnap(songHalf[e], (songHalf[e] != 32'd0), 1'b1, 3'(e), 1'b0, $sformatf("e%0d play c%0d", e, c));
      if (playLimit >= playLen)
         for (int c = 0; c < GAPC; c++)
            pushSnap(32'd0, 1'b0, 1'b1, 3'(e), 1'b0, $sformatf("e%0d gap c%0d", e, c));
   endtask

   task automatic applyStimulus(input logic s, input logic p);
      @(negedge clk);
      bus.start = s;
      bus.stop  = p;
   endtask

   task automatic releaseInputs();
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
   endtask

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         checkCount++;
         $display("[TB] FAIL drain timeout: %0d expected samples still pending, required 0", expQ.size());
         expQ.delete();
         tagQ.delete();
      end
   endtask

   // Monitor: compares one expected snapshot per clock, sampled shortly after the rising edge.
   initial begin
      snap_t e;
      string t;
      forever begin
         @(posedge clk);
         #2;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checkOutput(t, e);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", passCount, checkCount + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      snap_t z;
      z = '0;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.loop_en = 1'b0;
`ifdef MELODY_TRANSPOSE_EN
      octave_up = 1'b1;
`endif
      @(negedge clk);
      pushIdle(2, "in reset");
      waitDrain(10);
      @(negedge clk);
      reset = 1'b1;
      pushIdle(2, "after reset");
      waitDrain(10);

      // Full song without looping; a mid-song start pulse must not restart it.
      applyStimulus(1'b1, 1'b0);
      for (int e = 0; e < 8; e++) pushEntry(e, 1000);
      pushSnap(32'd0, 1'b0, 1'b0, 3'd7, 1'b1, "song done");
      pushIdle(2, "idle after done");
      releaseInputs();
      repeat (40) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waitDrain(400);

      // Looping: entry 7 wraps to entry 0, then stop mid-PLAY.
      bus.loop_en = 1'b1;
      applyStimulus(1'b1, 1'b0);
      for (int e = 0; e < 8; e++) pushEntry(e, 1000);
      pushEntry(0, 6);
      releaseInputs();
      waitDrain(400);
      applyStimulus(1'b0, 1'b1);
      pushIdle(2, "stop in loop");
      releaseInputs();
      bus.loop_en = 1'b0;
      waitDrain(20);

      // Stop during entry 7 PLAY: no song_done.
      applyStimulus(1'b1, 1'b0);
      for (int e = 0; e < 7; e++) pushEntry(e, 1000);
      pushEntry(7, 10);
      releaseInputs();
      waitDrain(400);
      applyStimulus(1'b0, 1'b1);
      pushIdle(3, "stop in e7");
      releaseInputs();
      waitDrain(20);

      // Simultaneous start and stop in IDLE stays idle.
      applyStimulus(1'b1, 1'b1);
      pushIdle(3, "start+stop idle");
      releaseInputs();
      waitDrain(20);

      // Asynchronous reset mid-PLAY clears outputs without a clock edge.
      applyStimulus(1'b1, 1'b0);
      pushEntry(0, 3);
      releaseInputs();
      waitDrain(40);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("async reset", z);
      pushIdle(2, "held in reset");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      pushIdle(2, "idle after reset");
      waitDrain(20);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
